comp: RTL and testbench

COMP -- requirements
Module: comp

---
 rtl/comp.sv | 61 ++++++
 tb/tb_comp.sv | 132 +++++++++++++
 2 files changed

// File: rtl/comp.sv
// Bit-error comparator: registered XOR mask, per-sample mismatch count and running error total.
// Define COMP_SATURATE_EN to make total_error saturate at 8'hFF instead of wrapping modulo 256.
module comp (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] A,
    input  logic [7:0] B,
    output logic [7:0] error,
    output logic [7:0] count,
    output logic [7:0] total_error
);

    localparam int DATA_W = 8;

    logic [DATA_W-1:0] w_diff;
    logic [3:0]        w_ones;
    logic [DATA_W-1:0] r_error_p0;
    logic [DATA_W-1:0] r_count_p0;
    logic [DATA_W-1:0] r_total_p0;

    function automatic logic [3:0] popcount8(input logic [DATA_W-1:0] v);
        logic [3:0] n;
        n = 4'd0;
        for (int i = 0; i < DATA_W; i++) begin
            n = n + {3'b000, v[i]};
        end
        return n;
    endfunction

    function automatic logic [DATA_W-1:0] accumulate(input logic [DATA_W-1:0] acc,
                                                     input logic [3:0]        inc);
`ifdef COMP_SATURATE_EN
        logic [DATA_W:0] sum;
        sum = {1'b0, acc} + {5'b00000, inc};
        return sum[DATA_W] ? {DATA_W{1'b1}} : sum[DATA_W-1:0];
`else
        return acc + {4'b0000, inc};
`endif
    endfunction

    assign w_diff = A ^ B;
    assign w_ones = popcount8(w_diff);

    // Stage p0: all three outputs register the same A/B sample
    always_ff @(posedge clk) begin
        if (rst) begin
            r_error_p0 <= '0;
            r_count_p0 <= '0;
            r_total_p0 <= '0;
        end else begin
            r_error_p0 <= w_diff;
            r_count_p0 <= {4'b0000, w_ones};
            r_total_p0 <= accumulate(r_total_p0, w_ones);
        end
    end

    assign error       = r_error_p0;
    assign count       = r_count_p0;
    assign total_error = r_total_p0;

endmodule

// File: tb/tb_comp.sv
// Directed self-checking bench for comp: reset, vector table, hold, overflow and mid-run reset.
`timescale 1ns/1ps
module tb_comp;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] A = 8'h00;
    logic [7:0] B = 8'h00;
    logic [7:0] error;
    logic [7:0] count;
    logic [7:0] total_error;

    int checks = 0;
    int failures = 0;

    comp dut (
        .clk(clk),
        .rst(rst),
        .A(A),
        .B(B),
        .error(error),
        .count(count),
        .total_error(total_error)
    );

    always #5 clk = ~clk;

    task automatic step(input logic [7:0] a, input logic [7:0] b);
        A = a;
        B = b;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step(8'h00, 8'h00);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step(8'h00, 8'hFF);
        step(8'h00, 8'hFF);
        checks++; if (error !== 8'h00) begin failures++; $display("FAIL reset_error got=%h exp=00", error); end
        checks++; if (count !== 8'd0) begin failures++; $display("FAIL reset_count got=%0d exp=0", count); end
        checks++; if (total_error !== 8'd0) begin failures++; $display("FAIL reset_total got=%0d exp=0", total_error); end
        rst = 1'b0;
        step(8'h00, 8'hFF);
        checks++; if (error !== 8'hFF) begin failures++; $display("FAIL post_reset_error got=%h exp=ff", error); end
        checks++; if (count !== 8'd8) begin failures++; $display("FAIL post_reset_count got=%0d exp=8", count); end
        checks++; if (total_error !== 8'd8) begin failures++; $display("FAIL post_reset_total got=%0d exp=8", total_error); end
    endtask

    task automatic test_vectors();
        logic [7:0] va [5] = '{8'd8, 8'd100, 8'd250, 8'd0,   8'hFB};
        logic [7:0] vb [5] = '{8'd7, 8'd120, 8'd250, 8'hFB, 8'hFB};
        logic [7:0] ee [5] = '{8'h0F, 8'h1C, 8'h00, 8'hFB, 8'h00};
        logic [7:0] ec [5] = '{8'd4, 8'd3, 8'd0, 8'd7, 8'd0};
        logic [7:0] et [5] = '{8'd4, 8'd7, 8'd7, 8'd14, 8'd14};
        do_reset();
        for (int i = 0; i < 5; i++) begin
            step(va[i], vb[i]);
            checks++; if (error !== ee[i]) begin failures++; $display("FAIL vec%0d_error got=%h exp=%h", i, error, ee[i]); end
            checks++; if (count !== ec[i]) begin failures++; $display("FAIL vec%0d_count got=%0d exp=%0d", i, count, ec[i]); end
            checks++; if (total_error !== et[i]) begin failures++; $display("FAIL vec%0d_total got=%0d exp=%0d", i, total_error, et[i]); end
        end
    endtask

    task automatic test_hold();
        logic [7:0] exp_total;
        do_reset();
        exp_total = 8'd0;
        for (int i = 0; i < 5; i++) begin
            step(8'd8, 8'd7);
            exp_total = exp_total + 8'd4;
            checks++; if (count !== 8'd4) begin failures++; $display("FAIL hold%0d_count got=%0d exp=4", i, count); end
            checks++; if (total_error !== exp_total) begin failures++; $display("FAIL hold%0d_total got=%0d exp=%0d", i, total_error, exp_total); end
        end
    endtask

    task automatic test_overflow();
        logic [7:0] exp_final;
`ifdef COMP_SATURATE_EN
        exp_final = 8'd255;
`else
        exp_final = 8'd0;
`endif
        do_reset();
        for (int i = 0; i < 31; i++) step(8'h00, 8'hFF);
        checks++; if (total_error !== 8'd248) begin failures++; $display("FAIL ovf31_total got=%0d exp=248", total_error); end
        step(8'h00, 8'hFF);
        checks++; if (total_error !== exp_final) begin failures++; $display("FAIL ovf32_total got=%0d exp=%0d", total_error, exp_final); end
        checks++; if (count !== 8'd8) begin failures++; $display("FAIL ovf32_count got=%0d exp=8", count); end
`ifdef COMP_SATURATE_EN
        step(8'h00, 8'hFF);
        checks++; if (total_error !== 8'd255) begin failures++; $display("FAIL ovf_hold_total got=%0d exp=255", total_error); end
`else
        step(8'h00, 8'hFF);
        checks++; if (total_error !== 8'd8) begin failures++; $display("FAIL ovf_wrap_total got=%0d exp=8", total_error); end
`endif
    endtask

    task automatic test_mid_reset();
        do_reset();
        step(8'd8, 8'd7);
        step(8'd100, 8'd120);
        step(8'd0, 8'hFB);
        checks++; if (total_error !== 8'd14) begin failures++; $display("FAIL mid_pre_total got=%0d exp=14", total_error); end
        rst = 1'b1;
        step(8'h00, 8'hFF);
        checks++; if (error !== 8'h00) begin failures++; $display("FAIL mid_rst_error got=%h exp=00", error); end
        checks++; if (count !== 8'd0) begin failures++; $display("FAIL mid_rst_count got=%0d exp=0", count); end
        checks++; if (total_error !== 8'd0) begin failures++; $display("FAIL mid_rst_total got=%0d exp=0", total_error); end
        rst = 1'b0;
        step(8'd8, 8'd7);
        checks++; if (error !== 8'h0F) begin failures++; $display("FAIL mid_restart_error got=%h exp=0f", error); end
        checks++; if (count !== 8'd4) begin failures++; $display("FAIL mid_restart_count got=%0d exp=4", count); end
        checks++; if (total_error !== 8'd4) begin failures++; $display("FAIL mid_restart_total got=%0d exp=4", total_error); end
    endtask

    initial begin
        test_reset();
        test_vectors();
        test_hold();
        test_overflow();
        test_mid_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
